// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage of the Toy-CPU.
// Holds the PC and issues one instruction read at a time to the memory
// controller. Returned words are buffered with their PCs in an in-order
// circular queue that the decoder drains through a valid/ready handshake.
// A redirect flushes the queue and restarts fetch at a new word-aligned PC.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mc_valid, mc_addr        fetch request to the memory controller (held until mc_done)
//   mc_done, mc_data         one-cycle response pulse and returned word
//   redirect, redirect_pc    one-cycle flush pulse and new PC (low two bits ignored)
//   dec_valid, dec_ready     queue head handshake with the decoder
//   dec_inst, dec_pc         queue head instruction and its PC
module inst_fetch #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mc_valid,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  input  logic                  mc_done,
  input  logic [DATA_WIDTH-1:0] mc_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_inst,
  output logic [ADDR_WIDTH-1:0] dec_pc
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  req_q, req_d;

  logic [DATA_WIDTH-1:0] inst_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] target_pc;

  // Redirect target forced to a word boundary.
  assign target_pc = redirect_pc & ~ADDR_WIDTH'(3);

  assign dec_valid = (count_q != '0);
  assign dec_inst  = inst_mem[head_q];
  assign dec_pc    = pc_mem[head_q];

  assign mc_valid  = req_q;
  assign mc_addr   = addr_q;

  // A pop in a redirect cycle is discarded along with the rest of the queue.
  assign pop = dec_valid && dec_ready && !redirect;

  // Fetch control: next state, next PC, request register and push decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    push    = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = target_pc;
        end else if ((count_q - CNT_W'(pop)) < DEPTH_C) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (redirect) begin
          pc_d = target_pc;
          if (mc_done) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (mc_done) begin
          push = 1'b1;
          // Back-to-back issue keeps mc_valid high with no bubble.
          if ((count_q + CNT_W'(1) - CNT_W'(pop)) < DEPTH_C) begin
            addr_d = pc_q;
            pc_d   = pc_q + ADDR_WIDTH'(4);
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end

      DROP: begin
        if (redirect) begin
          pc_d = target_pc;
        end
        if (mc_done) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (redirect) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Fetch state, PC and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  // Instruction queue: storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
        inst_mem[PTR_W'(i)] <= '0;
        pc_mem[PTR_W'(i)]   <= '0;
      end
    end else begin
      if (push) begin
        inst_mem[tail_q] <= mc_data;
        pc_mem[tail_q]   <= addr_q;
      end
      if (redirect) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PTR_W'(1);
        if (pop)  head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule
